gg_cheat_engine: RTL and testbench

Consumer side of the Game Genie code loader. It accepts the 129-bit packed codes produced by the code-download path and keeps them in a register-based code table. Every cartridge read address the CPU presents is matched against the table. On a hit the block returns replacement data, which the system bus mux substitutes for the ROM data.

---
 rtl/gg_cheat_engine.sv | 158 +++++++++++++++
 tb/tb_gg_cheat_engine.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gg_cheat_engine.sv
// gg_cheat_engine: Game Genie code table with a one-cycle, fully pipelined read-override lookup.
// Define GG_COMPARE_EN to build the per-entry compare-value gate (cmp registers and comparators).
module gg_cheat_engine #(
    parameter int MAX_CODES = 32,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              gg_reset,
    input  logic              gg_en,
    input  logic [128:0]      gg_code,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_rd,
    output logic              gg_ovr,
    output logic [DATA_W-1:0] gg_data,
    output logic              gg_available,
    output logic              gg_full
);
    localparam int IDX_W  = (MAX_CODES > 1) ? $clog2(MAX_CODES) : 1;
    localparam int LANE_W = DATA_W / 2;

    // Entries hold the word address only; byte lane comes from the live cpu_addr[0].
    logic [MAX_CODES-1:0] r_valid;
    logic [ADDR_W-2:0]    r_addr [MAX_CODES];
    logic [DATA_W-1:0]    r_rep  [MAX_CODES];
    logic [MAX_CODES-1:0] r_byte;
`ifdef GG_COMPARE_EN
    logic [DATA_W-1:0]    r_cmp  [MAX_CODES];
    logic [MAX_CODES-1:0] r_cmp_en;
`endif

    logic              r_ovr_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic              r_avail;
    logic              r_full;

    logic                 w_load;
    logic [ADDR_W-2:0]    w_ld_addr;
    logic                 w_dup_found;
    logic                 w_free_found;
    logic [IDX_W-1:0]     w_dup_idx;
    logic [IDX_W-1:0]     w_free_idx;
    logic [IDX_W-1:0]     w_wr_idx;
    logic                 w_wr_en;
    logic [MAX_CODES-1:0] w_valid_nxt;

    logic [LANE_W-1:0]    w_lane;
    logic [MAX_CODES-1:0] w_hit_vec;
    logic                 w_hit;
    logic [DATA_W-1:0]    w_res;
    logic                 w_ovr_nxt;
    logic                 w_unused;

    assign w_ld_addr = gg_code[65 +: ADDR_W-1];
    assign w_lane    = cpu_addr[0] ? cpu_data[LANE_W-1:0] : cpu_data[DATA_W-1:LANE_W];
    assign w_ovr_nxt = w_hit && gg_en && cpu_rd;

`ifdef GG_COMPARE_EN
    assign w_unused = ^{gg_code[127:98], gg_code[95:64+ADDR_W], gg_code[64],
                        gg_code[63:32+DATA_W], gg_code[31:DATA_W]};
`else
    assign w_unused = ^{gg_code[127:98], gg_code[96], gg_code[95:64+ADDR_W], gg_code[64],
                        gg_code[63:32], gg_code[31:DATA_W]};
`endif

    always_comb begin
        w_load       = gg_code[128] && !gg_reset;
        w_dup_found  = 1'b0;
        w_free_found = 1'b0;
        w_dup_idx    = '0;
        w_free_idx   = '0;
        for (int i = 0; i < MAX_CODES; i++) begin
            if (!w_dup_found && r_valid[i] && (r_addr[i] == w_ld_addr)) begin
                w_dup_found = 1'b1;
                w_dup_idx   = IDX_W'(i);
            end
            if (!w_free_found && !r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
        w_wr_en     = w_load && (w_dup_found || w_free_found);
        w_wr_idx    = w_dup_found ? w_dup_idx : w_free_idx;
        w_valid_nxt = r_valid;
        if (gg_reset)
            w_valid_nxt = '0;
        else if (w_wr_en)
            w_valid_nxt[w_wr_idx] = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        r_valid <= w_valid_nxt;
        if (w_wr_en) begin
            r_addr[w_wr_idx] <= w_ld_addr;
            r_rep[w_wr_idx]  <= gg_code[DATA_W-1:0];
            r_byte[w_wr_idx] <= gg_code[97];
`ifdef GG_COMPARE_EN
            r_cmp[w_wr_idx]    <= gg_code[32 +: DATA_W];
            r_cmp_en[w_wr_idx] <= gg_code[96];
`endif
        end
    end

    always_comb begin
        w_hit_vec = '0;
        for (int i = 0; i < MAX_CODES; i++) begin
            w_hit_vec[i] = r_valid[i] && (r_addr[i] == cpu_addr[ADDR_W-1:1]);
`ifdef GG_COMPARE_EN
            if (r_cmp_en[i]) begin
                if (r_byte[i])
                    w_hit_vec[i] = w_hit_vec[i] && (w_lane == r_cmp[i][LANE_W-1:0]);
                else
                    w_hit_vec[i] = w_hit_vec[i] && (cpu_data == r_cmp[i]);
            end
`endif
        end
    end

    // Scan from the top so the lowest-index hit is the last one assigned.
    always_comb begin
        w_hit = 1'b0;
        w_res = '0;
        for (int i = MAX_CODES - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit = 1'b1;
                if (!r_byte[i])
                    w_res = r_rep[i];
                else if (cpu_addr[0])
                    w_res = {cpu_data[DATA_W-1:LANE_W], r_rep[i][LANE_W-1:0]};
                else
                    w_res = {r_rep[i][LANE_W-1:0], cpu_data[LANE_W-1:0]};
            end
        end
    end

    // Stage p0 -> p1: registered lookup result and table status.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ovr_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_avail   <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_ovr_p1 <= w_ovr_nxt;
            if (w_ovr_nxt)
                r_data_p1 <= w_res;
            r_avail <= |w_valid_nxt;
            r_full  <= &w_valid_nxt;
        end
    end

    assign gg_ovr       = r_ovr_p1;
    assign gg_data      = r_data_p1;
    assign gg_available = r_avail;
    assign gg_full      = r_full;
endmodule

// File: tb/tb_gg_cheat_engine.sv
// Testbench for gg_cheat_engine: directed scenarios plus randomized traffic against a table model.
module tb_gg_cheat_engine;
    localparam int MAX_CODES = 32;
    localparam int ADDR_W    = 24;
`ifdef GG_COMPARE_EN
    localparam bit CMP_BUILT = 1'b1;
`else
    localparam bit CMP_BUILT = 1'b0;
`endif

    logic         clk_sys = 1'b0;
    logic         reset = 1'b1;
    logic         gg_reset = 1'b1;
    logic         gg_en = 1'b1;
    logic [128:0] gg_code = '0;
    logic [23:0]  cpu_addr = '0;
    logic [15:0]  cpu_data = '0;
    logic         cpu_rd = 1'b0;
    logic         gg_ovr;
    logic [15:0]  gg_data;
    logic         gg_available;
    logic         gg_full;

    always #5 clk_sys = ~clk_sys;

    gg_cheat_engine #(.MAX_CODES(MAX_CODES), .ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk_sys(clk_sys), .reset(reset), .gg_reset(gg_reset), .gg_en(gg_en),
        .gg_code(gg_code), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rd(cpu_rd),
        .gg_ovr(gg_ovr), .gg_data(gg_data), .gg_available(gg_available), .gg_full(gg_full)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference table: entries in index order, addresses kept as full byte addresses.
    bit          m_valid [MAX_CODES];
    logic [23:0] m_addr  [MAX_CODES];
    logic [15:0] m_cmp   [MAX_CODES];
    logic [15:0] m_rep   [MAX_CODES];
    bit          m_cmpen [MAX_CODES];
    bit          m_byte  [MAX_CODES];

    logic        e_ovr = 1'b0;
    logic [15:0] e_data = '0;
    logic        e_avail = 1'b0;
    logic        e_full = 1'b0;

    function automatic logic [128:0] make_code(input bit byte_m, input bit cmp_en,
                                               input logic [23:0] a, input logic [15:0] c,
                                               input logic [15:0] r);
        logic [128:0] k;
        k[128]    = 1'b1;
        k[127:98] = 30'($urandom);
        k[97]     = byte_m;
        k[96]     = cmp_en;
        k[95:88]  = 8'($urandom);
        k[87:64]  = a;
        k[63:48]  = 16'($urandom);
        k[47:32]  = c;
        k[31:16]  = 16'($urandom);
        k[15:0]   = r;
        return k;
    endfunction

    function automatic void model_lookup(input logic [23:0] a, input logic [15:0] d,
                                         output bit hit, output logic [15:0] res);
        logic [7:0] lane;
        bit ok;
        hit = 1'b0;
        res = '0;
        lane = a[0] ? d[7:0] : d[15:8];
        for (int i = 0; i < MAX_CODES; i++) begin
            if (!hit && m_valid[i] && (m_addr[i] >> 1) == (a >> 1)) begin
                ok = 1'b1;
                if (CMP_BUILT && m_cmpen[i])
                    ok = m_byte[i] ? (lane == m_cmp[i][7:0]) : (d == m_cmp[i]);
                if (ok) begin
                    hit = 1'b1;
                    if (!m_byte[i])
                        res = m_rep[i];
                    else if (a[0])
                        res = {d[15:8], m_rep[i][7:0]};
                    else
                        res = {m_rep[i][7:0], d[7:0]};
                end
            end
        end
    endfunction

    function automatic void model_load(input logic [128:0] k);
        int idx;
        logic [23:0] a;
        a = k[87:64];
        idx = -1;
        for (int i = 0; i < MAX_CODES; i++)
            if (idx < 0 && m_valid[i] && (m_addr[i] >> 1) == (a >> 1)) idx = i;
        for (int i = 0; i < MAX_CODES; i++)
            if (idx < 0 && !m_valid[i]) idx = i;
        if (idx >= 0) begin
            m_valid[idx] = 1'b1;
            m_addr[idx]  = a;
            m_cmp[idx]   = k[47:32];
            m_rep[idx]   = k[15:0];
            m_cmpen[idx] = k[96];
            m_byte[idx]  = k[97];
        end
    endfunction

    // Predict the outputs for the current inputs, update the model, then advance one clock.
    task automatic step();
        bit h;
        logic [15:0] r;
        int n;
        model_lookup(cpu_addr, cpu_data, h, r);
        if (reset) begin
            e_ovr = 1'b0;
            e_data = '0;
        end else begin
            e_ovr = h && gg_en && cpu_rd;
            if (e_ovr) e_data = r;
        end
        if (gg_reset) begin
            for (int i = 0; i < MAX_CODES; i++) m_valid[i] = 1'b0;
        end else if (gg_code[128]) begin
            model_load(gg_code);
        end
        n = 0;
        for (int i = 0; i < MAX_CODES; i++) n += int'(m_valid[i]);
        e_avail = !reset && (n > 0);
        e_full  = !reset && (n == MAX_CODES);
        @(posedge clk_sys);
        #1;
        gg_code[128] = 1'b0;
    endtask

    task automatic load(input logic [128:0] k);
        gg_code = k;
        step();
    endtask

    task automatic rd(input logic [23:0] a, input logic [15:0] d);
        cpu_addr = a;
        cpu_data = d;
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        gg_reset = 1'b1;
        step();
        gg_reset = 1'b0;
        n_total++;
        if ({gg_ovr, gg_data, gg_available, gg_full} !== 19'h0)
            $display("FAIL reset_state: got ovr=%b data=%h avail=%b full=%b, want all 0",
                     gg_ovr, gg_data, gg_available, gg_full);
        else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if ({gg_available, gg_full} !== 2'b00)
            $display("FAIL empty_after_reset: got avail=%b full=%b, want 0 0", gg_available, gg_full);
        else n_pass++;
    endtask

    task automatic test_word_replace();
        load(make_code(1'b0, 1'b0, 24'h000200, 16'h0000, 16'h4E71));
        n_total++;
        if ({gg_available, gg_full} !== 2'b10)
            $display("FAIL load_status: got avail=%b full=%b, want 1 0", gg_available, gg_full);
        else n_pass++;
        rd(24'h000200, 16'h1234);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h4E71})
            $display("FAIL word_hit: got ovr=%b data=%h, want ovr=1 data=4e71", gg_ovr, gg_data);
        else n_pass++;
        rd(24'h000201, 16'h5555);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h4E71})
            $display("FAIL word_hit_odd: got ovr=%b data=%h, want ovr=1 data=4e71", gg_ovr, gg_data);
        else n_pass++;
        rd(24'h000202, 16'h1234);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b0, 16'h4E71})
            $display("FAIL word_miss: got ovr=%b data=%h, want ovr=0 data held 4e71", gg_ovr, gg_data);
        else n_pass++;
    endtask

    task automatic test_compare();
        load(make_code(1'b0, 1'b1, 24'h001000, 16'h6600, 16'h6000));
        rd(24'h001000, 16'h6600);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h6000})
            $display("FAIL cmp_pass: got ovr=%b data=%h, want ovr=1 data=6000", gg_ovr, gg_data);
        else n_pass++;
        rd(24'h001000, 16'h6700);
        n_total++;
        if (gg_ovr !== !CMP_BUILT)
            $display("FAIL cmp_gate: got ovr=%b, want %b", gg_ovr, !CMP_BUILT);
        else n_pass++;
        load(make_code(1'b1, 1'b1, 24'h001100, 16'h00C3, 16'h0077));
        rd(24'h001101, 16'h12C3);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h1277})
            $display("FAIL cmp_byte_lo: got ovr=%b data=%h, want ovr=1 data=1277", gg_ovr, gg_data);
        else n_pass++;
        rd(24'h001100, 16'hC312);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h7712})
            $display("FAIL cmp_byte_hi: got ovr=%b data=%h, want ovr=1 data=7712", gg_ovr, gg_data);
        else n_pass++;
        rd(24'h001101, 16'hC312);
        n_total++;
        if (gg_ovr !== !CMP_BUILT)
            $display("FAIL cmp_byte_gate: got ovr=%b, want %b", gg_ovr, !CMP_BUILT);
        else n_pass++;
    endtask

    task automatic test_byte_mode();
        load(make_code(1'b1, 1'b0, 24'h000301, 16'h0000, 16'h00AB));
        rd(24'h000300, 16'h1122);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'hAB22})
            $display("FAIL byte_even: got ovr=%b data=%h, want ovr=1 data=ab22", gg_ovr, gg_data);
        else n_pass++;
        rd(24'h000301, 16'h1122);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h11AB})
            $display("FAIL byte_odd: got ovr=%b data=%h, want ovr=1 data=11ab", gg_ovr, gg_data);
        else n_pass++;
    endtask

    task automatic test_capacity();
        logic [15:0] reps [MAX_CODES];
        int k;
        gg_reset = 1'b1;
        step();
        gg_reset = 1'b0;
        for (int i = 0; i < MAX_CODES; i++) begin
            reps[i] = 16'($urandom);
            load(make_code(1'b0, 1'b0, 24'h400000 + 24'(i * 4), 16'h0000, reps[i]));
            if (i == MAX_CODES - 2) begin
                n_total++;
                if (gg_full !== 1'b0) $display("FAIL not_full_yet: got full=%b, want 0", gg_full);
                else n_pass++;
            end
        end
        n_total++;
        if ({gg_available, gg_full} !== 2'b11)
            $display("FAIL full_flag: got avail=%b full=%b, want 1 1", gg_available, gg_full);
        else n_pass++;
        load(make_code(1'b0, 1'b0, 24'h7F0000, 16'h0000, 16'h1357));
        n_total++;
        if (gg_full !== 1'b1) $display("FAIL full_after_drop: got full=%b, want 1", gg_full);
        else n_pass++;
        rd(24'h7F0000, 16'h0000);
        n_total++;
        if (gg_ovr !== 1'b0) $display("FAIL dropped_code: got ovr=%b, want 0", gg_ovr);
        else n_pass++;
        load(make_code(1'b0, 1'b0, 24'h400015, 16'h0000, 16'hBEEF));
        rd(24'h400014, 16'h0000);
        n_total++;
        if ({gg_ovr, gg_data, gg_full} !== {1'b1, 16'hBEEF, 1'b1})
            $display("FAIL overwrite: got ovr=%b data=%h full=%b, want 1 beef 1", gg_ovr, gg_data, gg_full);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            k = (j == 0) ? 0 : ((j == 3) ? MAX_CODES - 1 : int'($urandom_range(1, 30)));
            if (k == 5) k = 6;
            rd(24'h400000 + 24'(k * 4), 16'($urandom));
            n_total++;
            if ({gg_ovr, gg_data} !== {1'b1, reps[k]})
                $display("FAIL full_read_%0d: got ovr=%b data=%h, want ovr=1 data=%h", k, gg_ovr, gg_data, reps[k]);
            else n_pass++;
        end
    endtask

    task automatic test_priority_clear();
        gg_reset = 1'b1;
        step();
        gg_reset = 1'b0;
        load(make_code(1'b0, 1'b0, 24'h005000, 16'h0000, 16'h1111));
        load(make_code(1'b0, 1'b0, 24'h005001, 16'h0000, 16'h2222));
        load(make_code(1'b0, 1'b0, 24'h006000, 16'h0000, 16'h3333));
        rd(24'h005000, 16'h0000);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'h2222})
            $display("FAIL same_word_overwrite: got ovr=%b data=%h, want ovr=1 data=2222", gg_ovr, gg_data);
        else n_pass++;
        gg_reset = 1'b1;
        load(make_code(1'b0, 1'b0, 24'h007000, 16'h0000, 16'h4444));
        gg_reset = 1'b0;
        n_total++;
        if ({gg_available, gg_full} !== 2'b00)
            $display("FAIL clear_wins: got avail=%b full=%b, want 0 0", gg_available, gg_full);
        else n_pass++;
        rd(24'h007000, 16'h0000);
        rd(24'h005000, 16'h0000);
        rd(24'h006000, 16'h0000);
        n_total++;
        if ({gg_ovr, gg_available} !== 2'b00)
            $display("FAIL after_clear: got ovr=%b avail=%b, want 0 0", gg_ovr, gg_available);
        else n_pass++;
    endtask

    task automatic test_reset_enable();
        load(make_code(1'b0, 1'b0, 24'h008000, 16'h0000, 16'hA5A5));
        rd(24'h008000, 16'h0000);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b1, 16'hA5A5})
            $display("FAIL pre_reset_hit: got ovr=%b data=%h, want ovr=1 data=a5a5", gg_ovr, gg_data);
        else n_pass++;
        reset = 1'b1;
        rd(24'h008000, 16'h0000);
        reset = 1'b0;
        n_total++;
        if ({gg_ovr, gg_data, gg_available} !== 18'h0)
            $display("FAIL reset_lookup: got ovr=%b data=%h avail=%b, want 0 0000 0", gg_ovr, gg_data, gg_available);
        else n_pass++;
        rd(24'h008000, 16'h0000);
        n_total++;
        if ({gg_ovr, gg_data, gg_available} !== {1'b1, 16'hA5A5, 1'b1})
            $display("FAIL table_retained: got ovr=%b data=%h avail=%b, want 1 a5a5 1", gg_ovr, gg_data, gg_available);
        else n_pass++;
        gg_en = 1'b0;
        rd(24'h008000, 16'h0000);
        n_total++;
        if ({gg_ovr, gg_data} !== {1'b0, 16'hA5A5})
            $display("FAIL gg_en_off: got ovr=%b data=%h, want ovr=0 data=a5a5", gg_ovr, gg_data);
        else n_pass++;
        gg_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [23:0] seq [6];
        logic        exp_ovr;
        seq[0] = 24'h008000; seq[1] = 24'h008002; seq[2] = 24'h008001;
        seq[3] = 24'h009000; seq[4] = 24'h008000; seq[5] = 24'h008000;
        cpu_rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_addr = seq[i];
            cpu_data = 16'($urandom);
            step();
            exp_ovr = (seq[i] >> 1) == 24'h004000;
            n_total++;
            if (gg_ovr !== exp_ovr || (exp_ovr && gg_data !== 16'hA5A5) ||
                {gg_ovr, gg_data} !== {e_ovr, e_data})
                $display("FAIL b2b_%0d: got ovr=%b data=%h, want ovr=%b data=%h", i, gg_ovr, gg_data, e_ovr, e_data);
            else n_pass++;
        end
        cpu_rd = 1'b0;
    endtask

    task automatic test_random();
        logic [23:0] pool [40];
        logic [15:0] dset [4];
        dset[0] = 16'h1234; dset[1] = 16'h12AB; dset[2] = 16'hAB34; dset[3] = 16'hABAB;
        for (int k = 0; k < 40; k++) pool[k] = 24'h100000 + 24'(k * 2);
        gg_reset = 1'b1;
        step();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) < 30)
                gg_code = make_code(1'($urandom_range(1)), 1'($urandom_range(1)),
                                    pool[$urandom_range(39)] | 24'($urandom_range(1)),
                                    dset[$urandom_range(3)], 16'($urandom));
            gg_reset = ($urandom_range(99) < 2);
            reset    = ($urandom_range(99) < 3);
            gg_en    = ($urandom_range(99) < 90);
            cpu_rd   = ($urandom_range(99) < 80);
            cpu_addr = pool[$urandom_range(39)] | 24'($urandom_range(1));
            cpu_data = dset[$urandom_range(3)];
            step();
            n_total++;
            if ({gg_ovr, gg_data, gg_available, gg_full} !== {e_ovr, e_data, e_avail, e_full})
                $display("FAIL random_%0d: got ovr=%b data=%h avail=%b full=%b, want %b %h %b %b", c,
                         gg_ovr, gg_data, gg_available, gg_full, e_ovr, e_data, e_avail, e_full);
            else n_pass++;
        end
        reset = 1'b0;
        gg_reset = 1'b0;
        gg_en = 1'b1;
        cpu_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_replace();
        test_compare();
        test_byte_mode();
        test_capacity();
        test_priority_clear();
        test_reset_enable();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
